// File: rtl/mem_sweep_ctrl_if.sv
// mem_sweep_ctrl_if: command, stream and tensor-memory signals of mem_sweep_ctrl.
//
// Handshake rule for every valid/ready pair here (cmd, s_*, m_*): a transfer
// happens on a rising clk edge where valid && ready are both 1. A producer
// keeps valid and its payload steady until that edge. A consumer may drive
// ready without waiting for valid.
//
// Modports: slave is the sweep controller side; master is the side that
// issues commands, drives the stream and returns memory read data.
interface mem_sweep_ctrl_if #(
  parameter int DATA_SIZE = 64
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_store;
  logic [15:0]          cmd_entry;
  logic                 cmd_transpose;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 mem_write;
  logic [15:0]          mem_index2;
  logic [15:0]          mem_index1;
  logic [15:0]          mem_index0;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_store, cmd_entry, cmd_transpose,
    input  s_data, s_valid, m_ready, mem_rdata,
    output cmd_ready, s_ready, m_data, m_valid,
    output mem_write, mem_index2, mem_index1, mem_index0, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_store, cmd_entry, cmd_transpose,
    output s_data, s_valid, m_ready, mem_rdata,
    input  cmd_ready, s_ready, m_data, m_valid,
    input  mem_write, mem_index2, mem_index1, mem_index0, mem_wdata
  );
endinterface

// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: walks every (row, col) of one DIM x DIM tile of a 3-D tensor
// memory entry, either writing stream beats into it (store) or streaming its
// words out (load). Optional build macro MEM_SWEEP_TRANSPOSE_EN adds a
// column-major walk selected by cmd_transpose; without it the walk is
// row-major and cmd_transpose is ignored.
module mem_sweep_ctrl #(
  parameter int DIM       = 1,
  parameter int ENTRY_NUM = 1,
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_sweep_ctrl_if.slave      bus,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] DIM_M1    = 16'(DIM - 1);
  localparam logic [16:0] ENTRY_LIM = 17'(ENTRY_NUM);

  state_t      state_q, state_d;
  logic [15:0] r_q, r_d;
  logic [15:0] c_q, c_d;
  logic [15:0] entry_q, entry_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef MEM_SWEEP_TRANSPOSE_EN
  logic        tr_q, tr_d;
`endif

  logic beat;
  logic last;
  logic in_store;
  logic in_load;

  // Next-state: command accept, counter walk and completion
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    entry_d = entry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MEM_SWEEP_TRANSPOSE_EN
    tr_d    = tr_q;
`endif
    beat = ((state_q == S_STORE) && bus.s_valid) ||
           ((state_q == S_LOAD)  && bus.m_ready);
    last = (r_q == DIM_M1) && (c_q == DIM_M1);

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          r_d = 16'd0;
          c_d = 16'd0;
          if ({1'b0, bus.cmd_entry} >= ENTRY_LIM) begin
            // Out-of-range entry: reject without touching memory
            err_d = 1'b1;
          end else begin
            entry_d = bus.cmd_entry;
`ifdef MEM_SWEEP_TRANSPOSE_EN
            tr_d    = bus.cmd_transpose;
`endif
            state_d = bus.cmd_store ? S_STORE : S_LOAD;
          end
        end
      end
      S_STORE, S_LOAD: begin
        if (beat) begin
          if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            r_d     = 16'd0;
            c_d     = 16'd0;
          end else begin
`ifdef MEM_SWEEP_TRANSPOSE_EN
            if (tr_q) begin
              // Column-major: row is the fast counter
              if (r_q == DIM_M1) begin
                r_d = 16'd0;
                c_d = c_q + 16'd1;
              end else begin
                r_d = r_q + 16'd1;
              end
            end else
`endif
            begin
              // Row-major: column is the fast counter
              if (c_q == DIM_M1) begin
                c_d = 16'd0;
                r_d = r_q + 16'd1;
              end else begin
                c_d = c_q + 16'd1;
              end
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= 16'd0;
      c_q     <= 16'd0;
      entry_q <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_SWEEP_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      entry_q <= entry_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MEM_SWEEP_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end

  // Output decode; rst masks every strobe even if the state has not reset yet
  always_comb begin
    in_store       = (state_q == S_STORE) && !rst;
    in_load        = (state_q == S_LOAD)  && !rst;
    bus.cmd_ready  = (state_q == S_IDLE);
    bus.s_ready    = in_store;
    bus.mem_write  = in_store && bus.s_valid;
    bus.mem_wdata  = in_store ? DATA_SIZE'(bus.s_data) : '0;
    bus.m_valid    = in_load;
    bus.m_data     = in_load ? DATA_SIZE'(bus.mem_rdata) : '0;
    bus.mem_index2 = (in_store || in_load) ? entry_q : 16'd0;
    bus.mem_index1 = (in_store || in_load) ? r_q : 16'd0;
    bus.mem_index0 = (in_store || in_load) ? c_q : 16'd0;
    done           = done_q && !rst;
    err            = err_q && !rst;
    busy           = (state_q != S_IDLE);
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: directed bench for mem_sweep_ctrl. One DIM=2/ENTRY_NUM=2
// instance carries most scenarios; a DIM=1/ENTRY_NUM=1 instance covers the
// single-word tile. Each DUT sees a small tensor-memory model.
module tb_mem_sweep_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_sweep_ctrl_if #(.DATA_SIZE(64)) bus2 ();
  mem_sweep_ctrl_if #(.DATA_SIZE(64)) bus1 ();

  logic       done2, err2, busy2;
  logic [1:0] st2;
  logic       done1, err1, busy1;
  logic [1:0] st1;

  mem_sweep_ctrl #(.DIM(2), .ENTRY_NUM(2), .DATA_SIZE(64)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .done(done2), .err(err2), .busy(busy2), .state_dbg(st2)
  );

  mem_sweep_ctrl #(.DIM(1), .ENTRY_NUM(1), .DATA_SIZE(64)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .done(done1), .err(err1), .busy(busy1), .state_dbg(st1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tensor memory models: combinational read, write on rising clk
  logic [63:0] mem2 [0:1][0:1][0:1];
  logic [63:0] mem1;

  always @(posedge clk) begin
    if (bus2.mem_write)
      mem2[bus2.mem_index2[0]][bus2.mem_index1[0]][bus2.mem_index0[0]] <= bus2.mem_wdata;
    if (bus1.mem_write)
      mem1 <= bus1.mem_wdata;
  end

  assign bus2.mem_rdata = mem2[bus2.mem_index2[0]][bus2.mem_index1[0]][bus2.mem_index0[0]];
  assign bus1.mem_rdata = mem1;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    checks++;
    if ({bus2.mem_write, bus2.s_ready, bus2.m_valid, done2, err2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus2.mem_write, bus2.s_ready, bus2.m_valid, done2, err2});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus2.cmd_ready !== 1'b1 || busy2 !== 1'b0 || st2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b busy=%b st=%0d expected ready=1 busy=0 st=0",
               bus2.cmd_ready, busy2, st2);
    end
    checks++;
    if ({bus2.mem_index2, bus2.mem_index1, bus2.mem_index0} !== 48'd0) begin
      errors++;
      $display("FAIL reset_index: got %h expected 0",
               {bus2.mem_index2, bus2.mem_index1, bus2.mem_index0});
    end
  endtask

  task automatic test_store();
    step();
    bus2.cmd_valid = 1'b1;
    bus2.cmd_store = 1'b1;
    bus2.cmd_entry = 16'd1;
    bus2.cmd_transpose = 1'b0;
    #1;
    checks++;
    if (bus2.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL store_accept: cmd_ready got %b expected 1", bus2.cmd_ready);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      bus2.cmd_valid = 1'b0;
      bus2.s_valid = 1'b1;
      bus2.s_data = 64'(9 + i);
      #1;
      checks++;
      if (i <= 4) begin
        if (bus2.mem_write !== 1'b1 || bus2.mem_index2 !== 16'd1 ||
            bus2.mem_index1 !== 16'((i - 1) / 2) || bus2.mem_index0 !== 16'((i - 1) % 2) ||
            bus2.mem_wdata !== 64'(9 + i)) begin
          errors++;
          $display("FAIL store_write[%0d]: got we=%b idx=(%0d,%0d,%0d) wd=%0d expected we=1 idx=(1,%0d,%0d) wd=%0d",
                   i, bus2.mem_write, bus2.mem_index2, bus2.mem_index1, bus2.mem_index0,
                   bus2.mem_wdata, (i - 1) / 2, (i - 1) % 2, 9 + i);
        end
      end else if (bus2.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL store_nowrite[%0d]: mem_write got %b expected 0", i, bus2.mem_write);
      end
      checks++;
      if (done2 !== (i == 5) || bus2.cmd_ready !== (i == 6)) begin
        errors++;
        $display("FAIL store_done[%0d]: got done=%b ready=%b expected done=%b ready=%b",
                 i, done2, bus2.cmd_ready, (i == 5), (i == 6));
      end
    end
    bus2.s_valid = 1'b0;
  endtask

  task automatic test_load_stall();
    int b;
    b = 0;
    step();
    bus2.cmd_valid = 1'b1;
    bus2.cmd_store = 1'b0;
    bus2.cmd_entry = 16'd1;
    bus2.cmd_transpose = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      bus2.cmd_valid = 1'b0;
      bus2.m_ready = (i % 2 == 1);
      #1;
      checks++;
      if (i <= 7) begin
        if (bus2.m_valid !== 1'b1 || bus2.m_data !== 64'(10 + b) ||
            bus2.mem_index2 !== 16'd1 || bus2.mem_index1 !== 16'(b / 2) ||
            bus2.mem_index0 !== 16'(b % 2)) begin
          errors++;
          $display("FAIL load_beat[%0d]: got v=%b d=%0d idx=(%0d,%0d,%0d) expected v=1 d=%0d idx=(1,%0d,%0d)",
                   i, bus2.m_valid, bus2.m_data, bus2.mem_index2, bus2.mem_index1,
                   bus2.mem_index0, 10 + b, b / 2, b % 2);
        end
        if (bus2.m_ready) b++;
      end else if (bus2.m_valid !== 1'b0 || done2 !== 1'b1) begin
        errors++;
        $display("FAIL load_done: got v=%b done=%b expected v=0 done=1", bus2.m_valid, done2);
      end
    end
    bus2.m_ready = 1'b0;
    step();
    checks++;
    if (bus2.cmd_ready !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL load_idle: got ready=%b done=%b expected ready=1 done=0", bus2.cmd_ready, done2);
    end
  endtask

  task automatic test_transpose();
    logic [63:0] exp_d [4];
    int          exp_r [4];
    int          exp_c [4];
`ifdef MEM_SWEEP_TRANSPOSE_EN
    exp_d = '{64'd10, 64'd12, 64'd11, 64'd13};
    exp_r = '{0, 1, 0, 1};
    exp_c = '{0, 0, 1, 1};
`else
    exp_d = '{64'd10, 64'd11, 64'd12, 64'd13};
    exp_r = '{0, 0, 1, 1};
    exp_c = '{0, 1, 0, 1};
`endif
    step();
    bus2.cmd_valid = 1'b1;
    bus2.cmd_store = 1'b0;
    bus2.cmd_entry = 16'd1;
    bus2.cmd_transpose = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      bus2.cmd_valid = 1'b0;
      bus2.cmd_transpose = 1'b0;
      bus2.m_ready = 1'b1;
      #1;
      checks++;
      if (i < 4) begin
        if (bus2.m_data !== exp_d[i] || bus2.mem_index1 !== 16'(exp_r[i]) ||
            bus2.mem_index0 !== 16'(exp_c[i])) begin
          errors++;
          $display("FAIL transpose_beat[%0d]: got d=%0d r=%0d c=%0d expected d=%0d r=%0d c=%0d",
                   i, bus2.m_data, bus2.mem_index1, bus2.mem_index0, exp_d[i], exp_r[i], exp_c[i]);
        end
      end else if (done2 !== 1'b1) begin
        errors++;
        $display("FAIL transpose_done: got %b expected 1", done2);
      end
    end
    bus2.m_ready = 1'b0;
    step();
  endtask

  task automatic test_bad_entry();
    step();
    bus2.cmd_valid = 1'b1;
    bus2.cmd_store = 1'b1;
    bus2.cmd_entry = 16'd2;
    bus2.s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      bus2.cmd_valid = 1'b0;
      #1;
      checks++;
      if (err2 !== (i == 1) || busy2 !== 1'b0 || bus2.cmd_ready !== 1'b1 ||
          bus2.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL bad_entry[%0d]: got err=%b busy=%b ready=%b we=%b expected err=%b busy=0 ready=1 we=0",
                 i, err2, busy2, bus2.cmd_ready, bus2.mem_write, (i == 1));
      end
    end
    bus2.s_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    bus2.cmd_valid = 1'b1;
    bus2.cmd_store = 1'b1;
    bus2.cmd_entry = 16'd0;
    for (int i = 1; i <= 2; i++) begin
      step();
      bus2.cmd_valid = 1'b0;
      bus2.s_valid = 1'b1;
      bus2.s_data = 64'(19 + i);
      #1;
      checks++;
      if (bus2.mem_write !== 1'b1 || bus2.mem_index1 !== 16'd0 || bus2.mem_index0 !== 16'(i - 1)) begin
        errors++;
        $display("FAIL abort_pre[%0d]: got we=%b r=%0d c=%0d expected we=1 r=0 c=%0d",
                 i, bus2.mem_write, bus2.mem_index1, bus2.mem_index0, i - 1);
      end
    end
    step();
    rst = 1'b1;
    bus2.s_data = 64'd22;
    #1;
    checks++;
    if (bus2.mem_write !== 1'b0 || bus2.s_ready !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: got we=%b sr=%b done=%b expected 000", bus2.mem_write, bus2.s_ready, done2);
    end
    step();
    rst = 1'b0;
    bus2.s_valid = 1'b0;
    #1;
    checks++;
    if (st2 !== 2'd0 || busy2 !== 1'b0 || bus2.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got st=%0d busy=%b ready=%b expected st=0 busy=0 ready=1",
               st2, busy2, bus2.cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (done2 !== 1'b0) begin
        errors++;
        $display("FAIL abort_nodone[%0d]: got %b expected 0", i, done2);
      end
    end
    bus2.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      bus2.cmd_valid = 1'b0;
      bus2.s_valid = (i < 4);
      bus2.s_data = 64'(30 + i);
      #1;
      checks++;
      if (i == 0 && (bus2.mem_write !== 1'b1 || bus2.mem_index2 !== 16'd0 ||
          bus2.mem_index1 !== 16'd0 || bus2.mem_index0 !== 16'd0)) begin
        errors++;
        $display("FAIL restart_idx: got we=%b idx=(%0d,%0d,%0d) expected we=1 idx=(0,0,0)",
                 bus2.mem_write, bus2.mem_index2, bus2.mem_index1, bus2.mem_index0);
      end else if (i == 4 && done2 !== 1'b1) begin
        errors++;
        $display("FAIL restart_done: got %b expected 1", done2);
      end
    end
    checks++;
    if (mem2[0][0][0] !== 64'd30 || mem2[0][0][1] !== 64'd31 ||
        mem2[0][1][0] !== 64'd32 || mem2[0][1][1] !== 64'd33) begin
      errors++;
      $display("FAIL restart_mem: got %0d %0d %0d %0d expected 30 31 32 33",
               mem2[0][0][0], mem2[0][0][1], mem2[0][1][0], mem2[0][1][1]);
    end
    step();
  endtask

  task automatic test_dim1();
    step();
    bus1.cmd_valid = 1'b1;
    bus1.cmd_store = 1'b1;
    bus1.cmd_entry = 16'd0;
    #1;
    checks++;
    if (bus1.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL dim1_accept: got %b expected 1", bus1.cmd_ready);
    end
    step();
    bus1.cmd_valid = 1'b0;
    bus1.s_valid = 1'b1;
    bus1.s_data = 64'd42;
    #1;
    checks++;
    if (bus1.mem_write !== 1'b1 ||
        {bus1.mem_index2, bus1.mem_index1, bus1.mem_index0} !== 48'd0) begin
      errors++;
      $display("FAIL dim1_write: got we=%b idx=%h expected we=1 idx=0",
               bus1.mem_write, {bus1.mem_index2, bus1.mem_index1, bus1.mem_index0});
    end
    step();
    bus1.s_valid = 1'b0;
    #1;
    checks++;
    if (done1 !== 1'b1 || bus1.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL dim1_done: got done=%b ready=%b expected done=1 ready=0", done1, bus1.cmd_ready);
    end
    step();
    checks++;
    if (bus1.cmd_ready !== 1'b1 || done1 !== 1'b0 || mem1 !== 64'd42) begin
      errors++;
      $display("FAIL dim1_ready: got ready=%b done=%b mem=%0d expected ready=1 done=0 mem=42",
               bus1.cmd_ready, done1, mem1);
    end
  endtask

  // Hard bound on simulated time in case the DUT wedges a task
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus2.cmd_valid = 1'b0; bus2.cmd_store = 1'b0; bus2.cmd_entry = 16'd0;
    bus2.cmd_transpose = 1'b0; bus2.s_data = 64'd0; bus2.s_valid = 1'b0; bus2.m_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_store = 1'b0; bus1.cmd_entry = 16'd0;
    bus1.cmd_transpose = 1'b0; bus1.s_data = 64'd0; bus1.s_valid = 1'b0; bus1.m_ready = 1'b0;
    test_reset();
    test_store();
    test_load_stall();
    test_transpose();
    test_bad_entry();
    test_reset_mid();
    test_dim1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
